conv3x3_stream_ctrl: RTL and testbench



---
 rtl/conv3x3_stream_ctrl_if.sv | 34 +++
 rtl/conv3x3_stream_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_conv3x3_stream_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_stream_ctrl_if.sv
// Handshake/bus bundle for conv3x3_stream_ctrl: weight load, addressed input
// buffer writes, start/status and the valid/ready result stream.
interface conv3x3_stream_ctrl_if #(
  parameter int DW  = 8,
  parameter int IMG = 4
);
  localparam int AW = $clog2(IMG*IMG);
  localparam int CW = (IMG < 3) ? 1 : $clog2(IMG);

  logic            i_start;
  logic            i_weight_load;
  logic [9*DW-1:0] i_w_flat;
  logic            i_in_we;
  logic [AW-1:0]   i_in_addr;
  logic [DW-1:0]   i_in_data;
  logic [DW-1:0]   o_out_data;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [CW-1:0]   o_out_row;
  logic [CW-1:0]   o_out_col;
  logic            o_out_last;
  logic            o_busy;
  logic            o_done;

  modport master (
    output i_start, i_weight_load, i_w_flat, i_in_we, i_in_addr, i_in_data, i_out_ready,
    input  o_out_data, o_out_valid, o_out_row, o_out_col, o_out_last, o_busy, o_done
  );

  modport slave (
    input  i_start, i_weight_load, i_w_flat, i_in_we, i_in_addr, i_in_data, i_out_ready,
    output o_out_data, o_out_valid, o_out_row, o_out_col, o_out_last, o_busy, o_done
  );
endinterface

// File: rtl/conv3x3_stream_ctrl.sv
// 3x3 convolution controller over an IMG x IMG buffer with a streamed result port.
// Optional CONV_RELU_EN: clamp two's-complement negative sums to zero.
module sa3x3 #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            weight_load,
  input  logic [9*DW-1:0] w_flat,
  input  logic [DW-1:0]   act_in1,
  input  logic [DW-1:0]   act_in2,
  input  logic [DW-1:0]   act_in3,
  input  logic [DW-1:0]   psum_in1,
  input  logic [DW-1:0]   psum_in2,
  input  logic [DW-1:0]   psum_in3,
  output logic [DW-1:0]   psum_out1,
  output logic [DW-1:0]   psum_out2,
  output logic [DW-1:0]   psum_out3
);
  // r_w[i][j] = w_(i+1)(j+1); packed order matches the row-major w_flat layout
  logic [2:0][2:0][DW-1:0] r_w;
  logic [2:0][DW-1:0]      r_a1, r_a2;
  logic [2:0][DW-1:0]      w_act, w_pin, w_pout;

  assign w_act = {act_in3, act_in2, act_in1};
  assign w_pin = {psum_in3, psum_in2, psum_in1};

  always_ff @(posedge clk)
    if (weight_load) r_w <= w_flat;

  // Each lane is one window column; rows arrive bottom-first, so after three
  // beats the live input is row 0, r_a1 row 1 and r_a2 row 2.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_a1 <= '0;
      r_a2 <= '0;
    end else begin
      r_a1 <= w_act;
      r_a2 <= clear ? '0 : r_a1;
    end

  for (genvar j = 0; j < 3; j++) begin : g_col
    assign w_pout[j] = w_pin[j] + r_w[0][j]*w_act[j] + r_w[1][j]*r_a1[j] + r_w[2][j]*r_a2[j];
  end

  assign psum_out1 = w_pout[0];
  assign psum_out2 = w_pout[1];
  assign psum_out3 = w_pout[2];
endmodule

module conv3x3_stream_ctrl #(
  parameter int DW  = 8,
  parameter int IMG = 4
) (
  input logic                clk,
  input logic                rst,
  conv3x3_stream_ctrl_if.slave bus
);
  localparam int OS = IMG - 2;
  localparam int AW = $clog2(IMG*IMG);
  localparam int CW = (IMG < 3) ? 1 : $clog2(IMG);
  localparam logic [CW-1:0] LAST = CW'(OS-1);
  localparam logic [AW:0]   NPIX = (AW+1)'(IMG*IMG);

  typedef enum logic [2:0] {S_IDLE, S_FEED1, S_FEED2, S_FEED3, S_OUT, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_r, r_c, r_out_row, r_out_col;
  logic [DW-1:0]      r_out_data;
  logic               r_out_valid, r_out_last, r_busy, r_done;
  logic [DW-1:0]      r_mem [IMG*IMG];

  logic               w_feed, w_clear;
  logic [1:0]         w_row;
  logic [2:0][AW-1:0] w_addr;
  logic [2:0][DW-1:0] w_act;
  logic [DW-1:0]      w_p1, w_p2, w_p3, w_sum, w_res;

  always_ff @(posedge clk)
    if (bus.i_in_we && !r_busy && ({1'b0, bus.i_in_addr} < NPIX))
      r_mem[bus.i_in_addr] <= bus.i_in_data;

  always_comb begin
    w_feed = 1'b0;
    w_row  = 2'd0;
    case (r_state)
      S_FEED1: begin w_feed = 1'b1; w_row = 2'd2; end
      S_FEED2: begin w_feed = 1'b1; w_row = 2'd1; end
      S_FEED3: begin w_feed = 1'b1; w_row = 2'd0; end
      default: ;
    endcase
  end

  assign w_clear = (r_state == S_IDLE) || (r_state == S_FEED1);

  for (genvar j = 0; j < 3; j++) begin : g_lane
    assign w_addr[j] = AW'((int'(r_r) + int'(w_row)) * IMG + int'(r_c) + j);
    assign w_act[j]  = w_feed ? r_mem[w_addr[j]] : '0;
  end

  sa3x3 #(.DW(DW)) u_sa (
    .clk(clk), .rst(rst), .clear(w_clear),
    .weight_load(bus.i_weight_load), .w_flat(bus.i_w_flat),
    .act_in1(w_act[0]), .act_in2(w_act[1]), .act_in3(w_act[2]),
    .psum_in1({DW{1'b0}}), .psum_in2({DW{1'b0}}), .psum_in3({DW{1'b0}}),
    .psum_out1(w_p1), .psum_out2(w_p2), .psum_out3(w_p3)
  );

  assign w_sum = w_p1 + w_p2 + w_p3;
`ifdef CONV_RELU_EN
  assign w_res = w_sum[DW-1] ? '0 : w_sum;
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= S_IDLE;
      r_r         <= '0;
      r_c         <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE:
          if (bus.i_start) begin
            r_state <= S_FEED1;
            r_busy  <= 1'b1;
            r_r     <= '0;
            r_c     <= '0;
          end
        S_FEED1: r_state <= S_FEED2;
        S_FEED2: r_state <= S_FEED3;
        S_FEED3: begin
          r_state     <= S_OUT;
          r_out_data  <= w_res;
          r_out_row   <= r_r;
          r_out_col   <= r_c;
          r_out_last  <= (r_r == LAST) && (r_c == LAST);
          r_out_valid <= 1'b1;
        end
        S_OUT:
          if (bus.i_out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_r     <= '0;
              r_c     <= '0;
            end else begin
              r_state <= S_FEED1;
              if (r_c == LAST) begin
                r_c <= '0;
                r_r <= r_r + 1'b1;
              end else begin
                r_c <= r_c + 1'b1;
              end
            end
          end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end

  assign bus.o_out_data  = r_out_data;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_out_row   = r_out_row;
  assign bus.o_out_col   = r_out_col;
  assign bus.o_out_last  = r_out_last;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
endmodule

// File: tb/tb_conv3x3_stream_ctrl.sv
// Randomised bench for conv3x3_stream_ctrl: IMG=4 main instance plus an IMG=3
// instance, checked against a direct windowed-sum model.
module tb_conv3x3_stream_ctrl;
  localparam int DW  = 8;
  localparam int IMG = 4;
  localparam int OS  = IMG - 2;
  localparam int AW  = $clog2(IMG*IMG);
  localparam int CW  = $clog2(IMG);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv3x3_stream_ctrl_if #(.DW(DW), .IMG(IMG)) bus ();
  conv3x3_stream_ctrl #(.DW(DW), .IMG(IMG)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  conv3x3_stream_ctrl_if #(.DW(DW), .IMG(3)) bus3 ();
  conv3x3_stream_ctrl #(.DW(DW), .IMG(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  int n_chk  = 0;
  int n_fail = 0;
  int mx [IMG][IMG];
  int mw [3][3];

  function automatic logic [DW-1:0] expect_at(input int r, input int c);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += mw[i][j] * mx[r+i][c+j];
    s = s % (1 << DW);
`ifdef CONV_RELU_EN
    if (s >= (1 << (DW-1))) s = 0;
`endif
    return DW'(s);
  endfunction

  function automatic logic [9*DW-1:0] pack_w();
    logic [9*DW-1:0] wf;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        wf[(i*3+j)*DW +: DW] = DW'(mw[i][j]);
    return wf;
  endfunction

  task automatic load_all();
    @(negedge clk);
    bus.i_w_flat = pack_w();
    bus.i_weight_load = 1'b1;
    @(negedge clk);
    bus.i_weight_load = 1'b0;
    for (int a = 0; a < IMG*IMG; a++) begin
      bus.i_in_we = 1'b1;
      bus.i_in_addr = AW'(a);
      bus.i_in_data = DW'(mx[a/IMG][a%IMG]);
      @(negedge clk);
    end
    bus.i_in_we = 1'b0;
  endtask

  // Starts a run (committing centre_val to x[1][1] on the start edge), floods
  // ignored writes while busy, pulses start mid-run, stalls result stall_idx.
  task automatic run_and_check(input string tag, input int centre_val,
                               input int stall_idx, input int stall_len);
    int cyc, nres, scnt, first_v, er, ec;
    bit fin;
    logic [DW-1:0] e;
    bus.i_start = 1'b1;
    bus.i_out_ready = 1'b1;
    bus.i_in_we = 1'b1;
    bus.i_in_addr = AW'(IMG + 1);
    bus.i_in_data = DW'(centre_val);
    mx[1][1] = centre_val % (1 << DW);
    cyc = 0; nres = 0; scnt = 0; first_v = -1; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      bus.i_start = (cyc == 6);
      bus.i_in_we = 1'b1;
      bus.i_in_addr = AW'($urandom_range(0, IMG*IMG-1));
      bus.i_in_data = DW'($urandom);
      if (bus.o_out_valid && first_v < 0) first_v = cyc;
      if (bus.o_done) begin
        fin = 1'b1;
        bus.i_in_we = 1'b0;
        n_chk++;
        if (cyc != 4*OS*OS + 1 + stall_len) begin
          n_fail++; $display("FAIL %s done_cycle got=%0d exp=%0d", tag, cyc, 4*OS*OS+1+stall_len);
        end
        n_chk++;
        if (nres != OS*OS) begin
          n_fail++; $display("FAIL %s result_count got=%0d exp=%0d", tag, nres, OS*OS);
        end
      end else if (bus.o_out_valid) begin
        er = nres / OS; ec = nres % OS; e = expect_at(er, ec);
        n_chk++;
        if (bus.o_out_data !== e || bus.o_out_row !== CW'(er) || bus.o_out_col !== CW'(ec) ||
            bus.o_out_last !== (nres == OS*OS-1)) begin
          n_fail++;
          $display("FAIL %s result%0d got data=%0h row=%0d col=%0d last=%b exp data=%0h row=%0d col=%0d last=%b",
                   tag, nres, bus.o_out_data, bus.o_out_row, bus.o_out_col, bus.o_out_last,
                   e, er, ec, (nres == OS*OS-1));
        end
        if (nres == stall_idx && scnt < stall_len) begin
          bus.i_out_ready = 1'b0;
          scnt++;
          n_chk++;
          if (bus.o_busy !== 1'b1) begin
            n_fail++; $display("FAIL %s stall_busy got=%b exp=1", tag, bus.o_busy);
          end
        end else begin
          bus.i_out_ready = 1'b1;
          nres++;
        end
      end else if (cyc > 4*OS*OS + stall_len + 40) begin
        fin = 1'b1;
        bus.i_in_we = 1'b0;
        n_chk++; n_fail++;
        $display("FAIL %s timeout waiting for done after %0d cycles", tag, cyc);
      end
    end
    n_chk++;
    if (first_v != 4) begin
      n_fail++; $display("FAIL %s first_valid_cycle got=%0d exp=4", tag, first_v);
    end
    @(negedge clk);
    n_chk++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s done_pulse_end got done=%b busy=%b exp 0 0", tag, bus.o_done, bus.o_busy);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < IMG; i++)
      for (int j = 0; j < IMG; j++) mx[i][j] = $urandom_range(0, 255);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) mw[i][j] = $urandom_range(0, 255);
  endtask

  task automatic test_reset();
    bus.i_start = 0; bus.i_weight_load = 0; bus.i_w_flat = '0; bus.i_in_we = 0;
    bus.i_in_addr = '0; bus.i_in_data = '0; bus.i_out_ready = 0;
    bus3.i_start = 0; bus3.i_weight_load = 0; bus3.i_w_flat = '0; bus3.i_in_we = 0;
    bus3.i_in_addr = '0; bus3.i_in_data = '0; bus3.i_out_ready = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.o_out_valid !== 0 || bus.o_busy !== 0 || bus.o_done !== 0 || bus.o_out_last !== 0) begin
      n_fail++; $display("FAIL reset_flags got valid=%b busy=%b done=%b last=%b exp all 0",
                         bus.o_out_valid, bus.o_busy, bus.o_done, bus.o_out_last);
    end
    n_chk++;
    if (bus.o_out_data !== '0 || bus.o_out_row !== '0 || bus.o_out_col !== '0) begin
      n_fail++; $display("FAIL reset_data got data=%0h row=%0d col=%0d exp 0 0 0",
                         bus.o_out_data, bus.o_out_row, bus.o_out_col);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < IMG; i++) for (int j = 0; j < IMG; j++) mx[i][j] = 1;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mw[i][j] = 1;
    load_all();
    run_and_check("all_ones", 1, -1, 0);
  endtask

  task automatic test_centre();
    for (int i = 0; i < IMG; i++) for (int j = 0; j < IMG; j++) mx[i][j] = 4*i + j;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mw[i][j] = (i == 1 && j == 1) ? 1 : 0;
    load_all();
    run_and_check("centre", 5, -1, 0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < IMG; i++) for (int j = 0; j < IMG; j++) mx[i][j] = 1;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mw[i][j] = 255;
    load_all();
    run_and_check("wrap_ff", 1, -1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      fill_random();
      load_all();
      run_and_check("random", $urandom_range(0, 255), -1, 0);
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    load_all();
    run_and_check("backpressure", $urandom_range(0, 255), 1, 5);
  endtask

  task automatic test_rst_mid();
    fill_random();
    load_all();
    bus.i_start = 1'b1;
    bus.i_out_ready = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.o_out_valid !== 0 || bus.o_busy !== 0 || bus.o_done !== 0) begin
      n_fail++; $display("FAIL rst_mid_async got valid=%b busy=%b done=%b exp 0 0 0",
                         bus.o_out_valid, bus.o_busy, bus.o_done);
    end
    @(negedge clk);
    n_chk++;
    if (bus.o_out_valid !== 0 || bus.o_busy !== 0 || bus.o_done !== 0) begin
      n_fail++; $display("FAIL rst_mid_edge got valid=%b busy=%b done=%b exp 0 0 0",
                         bus.o_out_valid, bus.o_busy, bus.o_done);
    end
    rst = 1'b0;
    run_and_check("after_rst", $urandom_range(0, 255), -1, 0);
  endtask

  task automatic test_img3();
    logic [DW-1:0] e;
    int cyc;
    bit fin, seen;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mx[i][j] = $urandom_range(0, 255);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mw[i][j] = $urandom_range(0, 255);
    e = expect_at(0, 0);
    @(negedge clk);
    bus3.i_w_flat = pack_w();
    bus3.i_weight_load = 1'b1;
    @(negedge clk);
    bus3.i_weight_load = 1'b0;
    for (int a = 0; a < 16; a++) begin
      bus3.i_in_we = 1'b1;
      bus3.i_in_addr = 4'(a);
      bus3.i_in_data = (a < 9) ? DW'(mx[a/3][a%3]) : DW'($urandom);
      @(negedge clk);
    end
    bus3.i_in_we = 1'b0;
    bus3.i_start = 1'b1;
    bus3.i_out_ready = 1'b1;
    cyc = 0; fin = 1'b0; seen = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      bus3.i_start = 1'b0;
      if (bus3.o_out_valid && !seen) begin
        seen = 1'b1;
        n_chk++;
        if (cyc != 4 || bus3.o_out_data !== e || bus3.o_out_last !== 1'b1 ||
            bus3.o_out_row !== '0 || bus3.o_out_col !== '0) begin
          n_fail++;
          $display("FAIL img3_result got cyc=%0d data=%0h last=%b row=%0d col=%0d exp cyc=4 data=%0h last=1 row=0 col=0",
                   cyc, bus3.o_out_data, bus3.o_out_last, bus3.o_out_row, bus3.o_out_col, e);
        end
      end
      if (bus3.o_done) begin
        fin = 1'b1;
        n_chk++;
        if (cyc != 5 || !seen) begin
          n_fail++; $display("FAIL img3_done got cyc=%0d seen=%b exp cyc=5 seen=1", cyc, seen);
        end
      end else if (cyc > 40) begin
        fin = 1'b1;
        n_chk++; n_fail++;
        $display("FAIL img3_timeout no done after %0d cycles", cyc);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_centre();
    test_wrap();
    test_random();
    test_backpressure();
    test_rst_mid();
    test_img3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
